// File: rtl/computational_unit_param.sv
// Parametrised 4-bit-CPU datapath: register file, data_bus source mux, ALU, sequential multiplier.
// Optional build macro CU_SAT_EN: add saturates to all-ones and sub clamps to zero.
module computational_unit_param #(
  parameter int unsigned DW = 4
) (
  input  logic          clk,
  input  logic          sync_reset,
  input  logic [3:0]    ir_nibble,
  input  logic [3:0]    source_sel,
  input  logic [8:0]    reg_en,
  input  logic          x_sel,
  input  logic          y_sel,
  input  logic          i_sel,
  input  logic [DW-1:0] dm,
  input  logic [DW-1:0] i_pins,
  output logic [DW-1:0] data_bus,
  output logic [DW-1:0] x0,
  output logic [DW-1:0] x1,
  output logic [DW-1:0] y0,
  output logic [DW-1:0] y1,
  output logic [DW-1:0] m,
  output logic [DW-1:0] i,
  output logic [DW-1:0] r,
  output logic [DW-1:0] o_reg,
  output logic          r_eq_0,
  output logic          r_carry,
  output logic          busy
);

  localparam int unsigned CW = $clog2(DW);

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e          state_q, state_d;
  logic [2*DW-1:0] acc_q, acc_d, mcand_q, mcand_d, acc_step;
  logic [DW-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            hi_q, hi_d;
  logic [DW-1:0]   r_d, x_op, y_op, alu_res;
  logic            carry_d, eq_d, alu_carry;
  logic [DW:0]     sum, diff;
  logic [2:0]      func;
  logic            noop, is_mul;
  logic            unused_reg_en7;

  assign unused_reg_en7 = reg_en[7];
  assign func   = ir_nibble[2:0];
  assign noop   = ir_nibble[3] && (func == 3'b000 || func == 3'b111);
  assign is_mul = (func == 3'b011) || (func == 3'b100);
  assign busy   = (state_q == StMul);
  assign x_op   = x_sel ? x1 : x0;
  assign y_op   = y_sel ? y1 : y0;
  assign sum    = {1'b0, x_op} + {1'b0, y_op};
  assign diff   = {1'b0, x_op} - {1'b0, y_op};

  always_comb begin
    data_bus = '0;
    case (source_sel)
      4'd0: data_bus = x0;
      4'd1: data_bus = x1;
      4'd2: data_bus = y0;
      4'd3: data_bus = y1;
      4'd4: data_bus = r;
      4'd5: data_bus = m;
      4'd6: data_bus = i;
      4'd7: data_bus = dm;
      4'd8: data_bus = DW'(ir_nibble);
      4'd9: data_bus = i_pins;
      default: data_bus = '0;
    endcase
  end

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (func)
      3'b000: alu_res = '0 - x_op;
      3'b001: begin
        alu_res   = diff[DW-1:0];
        alu_carry = diff[DW];
`ifdef CU_SAT_EN
        if (diff[DW]) alu_res = '0;
`endif
      end
      3'b010: begin
        alu_res   = sum[DW-1:0];
        alu_carry = sum[DW];
`ifdef CU_SAT_EN
        if (sum[DW]) alu_res = '1;
`endif
      end
      3'b101: alu_res = x_op ^ y_op;
      3'b110: alu_res = x_op & y_op;
      3'b111: alu_res = ~x_op;
      default: alu_res = '0;
    endcase
  end

  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    r_d      = r;
    carry_d  = r_carry;
    eq_d     = r_eq_0;
    unique case (state_q)
      StIdle: begin
        if (reg_en[4] && !noop) begin
          if (is_mul) begin
            state_d  = StMul;
            acc_d    = '0;
            mcand_d  = {{DW{1'b0}}, x_op};
            mplier_d = y_op;
            cnt_d    = '0;
            hi_d     = (func == 3'b011);
          end else begin
            r_d     = alu_res;
            carry_d = alu_carry;
            eq_d    = (alu_res == '0);
          end
        end
      end
      StMul: begin
        // One shift-add step per edge; the final step writes r straight from the new sum.
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(DW - 1)) begin
          state_d = StIdle;
          r_d     = hi_q ? acc_step[2*DW-1:DW] : acc_step[DW-1:0];
          carry_d = 1'b0;
          eq_d    = (r_d == '0);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      hi_q     <= 1'b0;
      x0       <= '0;
      x1       <= '0;
      y0       <= '0;
      y1       <= '0;
      m        <= '0;
      i        <= '0;
      r        <= '0;
      o_reg    <= '0;
      r_eq_0   <= 1'b1;
      r_carry  <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      r        <= r_d;
      r_eq_0   <= eq_d;
      r_carry  <= carry_d;
      if (reg_en[0]) x0 <= data_bus;
      if (reg_en[1]) x1 <= data_bus;
      if (reg_en[2]) y0 <= data_bus;
      if (reg_en[3]) y1 <= data_bus;
      if (reg_en[5]) m <= data_bus;
      if (reg_en[6]) i <= i_sel ? i + m : data_bus;
      if (reg_en[8]) o_reg <= data_bus;
    end
  end

endmodule

// File: tb/tb_computational_unit_param.sv
// Scoreboard bench for computational_unit_param: DW=4 main instance plus a DW=8 multiply instance.
module tb_computational_unit_param;

  logic       clk = 1'b0;
  logic       sync_reset;
  logic [3:0] ir_nibble, source_sel;
  logic [8:0] reg_en;
  logic       x_sel, y_sel, i_sel;
  logic [3:0] dm, pins, data_bus, x0, x1, y0, y1, m, i, r, o_reg;
  logic       r_eq_0, r_carry, busy;
  logic [7:0] dm8, pins8, data_bus8, x0_8, x1_8, y0_8, y1_8, m_8, i_8, r_8, o_reg8;
  logic       r_eq_0_8, r_carry8, busy8;

  typedef struct packed {
    logic [3:0] r;
    logic       c;
    logic       z;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  computational_unit_param #(.DW(4)) dut (
    .clk(clk), .sync_reset(sync_reset), .ir_nibble(ir_nibble), .source_sel(source_sel),
    .reg_en(reg_en), .x_sel(x_sel), .y_sel(y_sel), .i_sel(i_sel), .dm(dm), .i_pins(pins),
    .data_bus(data_bus), .x0(x0), .x1(x1), .y0(y0), .y1(y1), .m(m), .i(i), .r(r),
    .o_reg(o_reg), .r_eq_0(r_eq_0), .r_carry(r_carry), .busy(busy)
  );

  computational_unit_param #(.DW(8)) dut8 (
    .clk(clk), .sync_reset(sync_reset), .ir_nibble(ir_nibble), .source_sel(source_sel),
    .reg_en(reg_en), .x_sel(x_sel), .y_sel(y_sel), .i_sel(i_sel), .dm(dm8), .i_pins(pins8),
    .data_bus(data_bus8), .x0(x0_8), .x1(x1_8), .y0(y0_8), .y1(y1_8), .m(m_8), .i(i_8),
    .r(r_8), .o_reg(o_reg8), .r_eq_0(r_eq_0_8), .r_carry(r_carry8), .busy(busy8)
  );

  function automatic exp_t model(input logic [2:0] f, input logic [3:0] x, input logic [3:0] y);
    exp_t       e;
    logic [7:0] p;
    e.r = 4'd0;
    e.c = 1'b0;
    p   = 8'(x) * 8'(y);
    case (f)
      3'b000: e.r = 4'd0 - x;
      3'b001: begin
        e.r = x - y;
        e.c = (x < y);
`ifdef CU_SAT_EN
        if (x < y) e.r = 4'd0;
`endif
      end
      3'b010: begin
        e.r = x + y;
        e.c = (5'(x) + 5'(y)) > 5'd15;
`ifdef CU_SAT_EN
        if (e.c) e.r = 4'hF;
`endif
      end
      3'b011: e.r = p[7:4];
      3'b100: e.r = p[3:0];
      3'b101: e.r = x ^ y;
      3'b110: e.r = x & y;
      default: e.r = ~x;
    endcase
    e.z = (e.r == 4'd0);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int idx, input logic [3:0] v, input logic [7:0] v8);
    source_sel = 4'd9;
    pins       = v;
    pins8      = v8;
    i_sel      = 1'b0;
    reg_en     = '0;
    reg_en[idx] = 1'b1;
    tick();
    reg_en = '0;
  endtask

  task automatic alu(input logic [3:0] nib, input logic xs, input logic ys);
    ir_nibble = nib;
    x_sel     = xs;
    y_sel     = ys;
    reg_en    = '0;
    reg_en[4] = 1'b1;
    tick();
    reg_en = '0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      tick();
    end
  endtask

  task automatic test_reset();
    sync_reset = 1'b1;
    tick();
    tick();
    sync_reset = 1'b0;
    n_checks++;
    if ({x0, x1, y0, y1, m, i, r, o_reg} !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_regs: got %h want 0", {x0, x1, y0, y1, m, i, r, o_reg});
    end
    n_checks++;
    if ({r_eq_0, r_carry, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_flags: got z/c/busy=%b want 100", {r_eq_0, r_carry, busy});
    end
    for (int s = 10; s < 16; s++) begin
      source_sel = 4'(s);
      #1;
      n_checks++;
      if (data_bus !== 4'd0) begin
        n_fail++;
        $display("FAIL bus_zero sel=%0d: got %h want 0", s, data_bus);
      end
    end
  endtask

  task automatic test_bus();
    logic [3:0] want [10];
    want = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h0, 4'h6, 4'h7, 4'hA, 4'hC, 4'hB};
    load(0, 4'h1, 8'h0);
    load(1, 4'h2, 8'h0);
    load(2, 4'h3, 8'h0);
    load(3, 4'h4, 8'h0);
    load(5, 4'h6, 8'h0);
    load(6, 4'h7, 8'h0);
    dm        = 4'hA;
    pins      = 4'hB;
    ir_nibble = 4'hC;
    for (int s = 0; s < 10; s++) begin
      source_sel = 4'(s);
      #1;
      n_checks++;
      if (data_bus !== want[s]) begin
        n_fail++;
        $display("FAIL bus_sel%0d: got %h want %h", s, data_bus, want[s]);
      end
    end
  endtask

  task automatic test_alu();
    exp_t       e;
    logic [2:0] funcs [6];
    logic [3:0] xv, yv;
    logic [2:0] f;
    funcs = '{3'b000, 3'b001, 3'b010, 3'b101, 3'b110, 3'b111};
    load(0, 4'h9, 8'h0);
    load(2, 4'h8, 8'h0);
    sb.push_back(model(3'b010, 4'h9, 4'h8));
    alu(4'b0010, 1'b0, 1'b0);
    e = sb.pop_front();
    n_checks++;
    if ({r, r_carry, r_eq_0} !== e) begin
      n_fail++;
      $display("FAIL add_9_8: got r=%h c=%b z=%b want r=%h c=%b z=%b",
               r, r_carry, r_eq_0, e.r, e.c, e.z);
    end
    load(0, 4'h3, 8'h0);
    load(2, 4'h5, 8'h0);
    sb.push_back(model(3'b001, 4'h3, 4'h5));
    alu(4'b0001, 1'b0, 1'b0);
    e = sb.pop_front();
    n_checks++;
    if ({r, r_carry, r_eq_0} !== e) begin
      n_fail++;
      $display("FAIL sub_3_5: got r=%h c=%b z=%b want r=%h c=%b z=%b",
               r, r_carry, r_eq_0, e.r, e.c, e.z);
    end
    for (int k = 0; k < 12; k++) begin
      xv = 4'($urandom);
      yv = 4'($urandom);
      f  = funcs[k % 6];
      load(1, xv, 8'h0);
      load(3, yv, 8'h0);
      sb.push_back(model(f, xv, yv));
      alu({1'b0, f}, 1'b1, 1'b1);
      e = sb.pop_front();
      n_checks++;
      if ({r, r_carry, r_eq_0} !== e) begin
        n_fail++;
        $display("FAIL alu f=%b x=%h y=%h: got r=%h c=%b z=%b want r=%h c=%b z=%b",
                 f, xv, yv, r, r_carry, r_eq_0, e.r, e.c, e.z);
      end
    end
  endtask

  task automatic test_mul();
    exp_t       e;
    int         cyc;
    logic [2:0] f;
    load(1, 4'hD, 8'h0);
    load(3, 4'hB, 8'h0);
    for (int k = 0; k < 2; k++) begin
      f = (k == 0) ? 3'b100 : 3'b011;
      sb.push_back(model(f, 4'hD, 4'hB));
      alu({1'b0, f}, 1'b1, 1'b1);
      wait_idle(cyc);
      n_checks++;
      if (cyc != 4) begin
        n_fail++;
        $display("FAIL mul_busy f=%b: got %0d cycles want 4", f, cyc);
      end
      e = sb.pop_front();
      n_checks++;
      if ({r, r_carry, r_eq_0} !== e) begin
        n_fail++;
        $display("FAIL mul_D_B f=%b: got r=%h c=%b z=%b want r=%h c=%b z=%b",
                 f, r, r_carry, r_eq_0, e.r, e.c, e.z);
      end
    end
  endtask

  task automatic test_mul_interference();
    exp_t e;
    int   cyc;
    sb.push_back(model(3'b011, 4'hD, 4'hB));
    alu(4'b0011, 1'b1, 1'b1);
    load(1, 4'h0, 8'h0);
    alu(4'b0010, 1'b1, 1'b1);
    load(8, 4'h5, 8'h0);
    wait_idle(cyc);
    n_checks++;
    if (cyc + 3 != 4) begin
      n_fail++;
      $display("FAIL intf_busy: got %0d cycles want 4", cyc + 3);
    end
    e = sb.pop_front();
    n_checks++;
    if ({r, r_carry, r_eq_0} !== e) begin
      n_fail++;
      $display("FAIL intf_product: got r=%h c=%b z=%b want r=%h c=%b z=%b",
               r, r_carry, r_eq_0, e.r, e.c, e.z);
    end
    n_checks++;
    if ({o_reg, x1} !== 8'h50) begin
      n_fail++;
      $display("FAIL intf_loads: got o_reg,x1=%h want 50", {o_reg, x1});
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   cyc;
    load(1, 4'hD, 8'h0);
    alu(4'b0100, 1'b1, 1'b1);
    tick();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_busy: got %b want 1", busy);
    end
    sync_reset = 1'b1;
    tick();
    sync_reset = 1'b0;
    n_checks++;
    if ({busy, r, r_eq_0} !== 6'b0_0000_1) begin
      n_fail++;
      $display("FAIL mid_reset: got busy=%b r=%h z=%b want 0 0 1", busy, r, r_eq_0);
    end
    load(1, 4'h7, 8'h0);
    load(3, 4'h6, 8'h0);
    sb.push_back(model(3'b100, 4'h7, 4'h6));
    alu(4'b0100, 1'b1, 1'b1);
    wait_idle(cyc);
    e = sb.pop_front();
    n_checks++;
    if (cyc != 4 || {r, r_carry, r_eq_0} !== e) begin
      n_fail++;
      $display("FAIL after_reset_mul: got cyc=%0d r=%h c=%b z=%b want 4 r=%h c=%b z=%b",
               cyc, r, r_carry, r_eq_0, e.r, e.c, e.z);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   cyc;
    sb.push_back(model(3'b011, 4'h7, 4'h6));
    alu(4'b0011, 1'b1, 1'b1);
    wait_idle(cyc);
    e = sb.pop_front();
    n_checks++;
    if (cyc != 4 || {r, r_carry, r_eq_0} !== e) begin
      n_fail++;
      $display("FAIL b2b_first: got cyc=%0d r=%h z=%b want 4 r=%h z=%b",
               cyc, r, r_eq_0, e.r, e.z);
    end
    sb.push_back(model(3'b100, 4'h7, 4'h0));
    alu(4'b0100, 1'b1, 1'b0);
    wait_idle(cyc);
    e = sb.pop_front();
    n_checks++;
    if (cyc != 4 || {r, r_carry, r_eq_0} !== e) begin
      n_fail++;
      $display("FAIL b2b_second: got cyc=%0d r=%h z=%b want 4 r=%h z=%b",
               cyc, r, r_eq_0, e.r, e.z);
    end
  endtask

  task automatic test_noop();
    exp_t e;
    load(0, 4'h9, 8'h0);
    load(2, 4'h8, 8'h0);
    sb.push_back(model(3'b010, 4'h9, 4'h8));
    alu(4'b0010, 1'b0, 1'b0);
    e = sb.pop_front();
    for (int k = 0; k < 2; k++) begin
      if (k == 1) alu(4'b1000, 1'b0, 1'b0);
      else alu(4'b1111, 1'b0, 1'b0);
      n_checks++;
      if ({r, r_carry, r_eq_0} !== e) begin
        n_fail++;
        $display("FAIL noop%0d: got r=%h c=%b z=%b want r=%h c=%b z=%b",
                 k, r, r_carry, r_eq_0, e.r, e.c, e.z);
      end
    end
    sb.push_back(model(3'b110, 4'h9, 4'h8));
    alu(4'b1110, 1'b0, 1'b0);
    e = sb.pop_front();
    n_checks++;
    if ({r, r_carry, r_eq_0} !== e) begin
      n_fail++;
      $display("FAIL qual_and: got r=%h c=%b z=%b want r=%h c=%b z=%b",
               r, r_carry, r_eq_0, e.r, e.c, e.z);
    end
    load(5, 4'h3, 8'h0);
    load(6, 4'hE, 8'h0);
    i_sel     = 1'b1;
    reg_en    = '0;
    reg_en[6] = 1'b1;
    tick();
    reg_en = '0;
    n_checks++;
    if (i !== 4'h1) begin
      n_fail++;
      $display("FAIL i_wrap: got %h want 1", i);
    end
  endtask

  task automatic test_dw8();
    logic [15:0] p;
    int          cyc;
    p = 16'(8'hFF) * 16'(8'hFF);
    load(1, 4'h0, 8'hFF);
    load(3, 4'h0, 8'hFF);
    alu(4'b0011, 1'b1, 1'b1);
    cyc = 0;
    while (busy8 === 1'b1 && cyc < 40) begin
      cyc++;
      tick();
    end
    n_checks++;
    if (cyc != 8 || {r_8, r_carry8, r_eq_0_8} !== {p[15:8], 2'b00}) begin
      n_fail++;
      $display("FAIL dw8_mul: got cyc=%0d r=%h c=%b z=%b want 8 r=%h c=0 z=0",
               cyc, r_8, r_carry8, r_eq_0_8, p[15:8]);
    end
  endtask

  initial begin
    sync_reset = 1'b1;
    ir_nibble  = '0;
    source_sel = '0;
    reg_en     = '0;
    x_sel      = 1'b0;
    y_sel      = 1'b0;
    i_sel      = 1'b0;
    dm         = '0;
    pins       = '0;
    dm8        = '0;
    pins8      = '0;
    test_reset();
    test_bus();
    test_alu();
    test_mul();
    test_mul_interference();
    test_reset_mid();
    test_back_to_back();
    test_noop();
    test_dw8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
